// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: upstream control for a 16:1 mux. Holds a 16-bit word on
// word_out and steps sel 0..15 so the mux emits the word serially, bit 0 first.
// A one-word pending buffer lets back-to-back words stream without a gap.
module mux_scan_sequencer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:15] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [0:15] word_out,
  output logic [0:3]  sel,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        ser_first,
  output logic        ser_last,
  output logic        busy
);

  localparam int unsigned WW = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(WW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_n;
  logic [0:15]   pend, pend_n, word_n;
  logic          pend_full, pend_full_n;
  logic [SW-1:0] sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept, at_last;
  logic          ser_valid_n, ser_first_n, ser_last_n, busy_n, in_ready_n;

  assign accept  = in_valid & in_ready;
  assign at_last = (state == SHIFT) && (SW'(sel) == SEL_LAST) && (cnt == CNT_LAST);

  // Local copy of the bit the downstream mux is currently selecting
  assign ser_out = word_out[sel];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: leave SHIFT only when the frame ends with nothing to follow
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_n = SHIFT;
        SHIFT:   if (at_last && !pend_full && !accept) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath next values: active/pending words, select and hold counter
  always_comb begin
    word_n      = word_out;
    pend_n      = pend;
    pend_full_n = pend_full;
    sel_n       = SW'(sel);
    cnt_n       = cnt;
    if (flush) begin
      pend_full_n = 1'b0;
      sel_n       = '0;
      cnt_n       = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_n = in_data;
            sel_n  = '0;
            cnt_n  = '0;
          end
        end
        SHIFT: begin
          if (at_last) begin
            sel_n = '0;
            cnt_n = '0;
            if (pend_full) begin
              word_n = pend;
              if (accept) pend_n = in_data;
              else        pend_full_n = 1'b0;
            end else if (accept) begin
              word_n = in_data;
            end
          end else begin
            if (cnt == CNT_LAST) begin
              cnt_n = '0;
              sel_n = SW'(SW'(sel) + SW'(1));
            end else begin
              cnt_n = CW'(cnt + CW'(1));
            end
            if (accept) begin
              pend_n      = in_data;
              pend_full_n = 1'b1;
            end
          end
        end
        default: begin
          sel_n = '0;
          cnt_n = '0;
        end
      endcase
    end
  end

  // Registered status outputs derived from the next-cycle state
  always_comb begin
    ser_valid_n = (state_n == SHIFT);
    ser_first_n = ser_valid_n && (sel_n == '0);
    ser_last_n  = ser_valid_n && (sel_n == SEL_LAST) && (cnt_n == CNT_LAST);
    busy_n      = ser_valid_n | pend_full_n;
    in_ready_n  = ~pend_full_n;
  end

  // Datapath and output registers; in_ready stays low while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out  <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      sel       <= '0;
      cnt       <= '0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      word_out  <= word_n;
      pend      <= pend_n;
      pend_full <= pend_full_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      ser_valid <= ser_valid_n;
      ser_first <= ser_first_n;
      ser_last  <= ser_last_n;
      busy      <= busy_n;
      in_ready  <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (BIT_CYCLES 1 and 3) share the
// stimulus; each is compared every cycle against a frame-position model.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] din = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;

  logic        rdy[2], sv[2], sf[2], sl[2], bz[2], so[2];
  logic [3:0]  sel4[2];
  logic [15:0] wo[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer #(.BIT_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(in_valid), .in_ready(rdy[0]),
    .flush(flush), .word_out(wo[0]), .sel(sel4[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .ser_first(sf[0]), .ser_last(sl[0]), .busy(bz[0])
  );

  mux_scan_sequencer #(.BIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(in_valid), .in_ready(rdy[1]),
    .flush(flush), .word_out(wo[1]), .sel(sel4[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .ser_first(sf[1]), .ser_last(sl[1]), .busy(bz[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a cycle position t in 0..16*BC-1
  int          bc[2] = '{1, 3};
  logic [15:0] m_act[2] = '{16'h0, 16'h0};
  logic [15:0] m_pend[2] = '{16'h0, 16'h0};
  int          m_t[2] = '{0, 0};
  bit          m_live[2] = '{1'b0, 1'b0};
  bit          m_pf[2] = '{1'b0, 1'b0};
  bit          m_rdy[2] = '{1'b0, 1'b0};

  task automatic model_step(input int k);
    bit acc;
    acc = in_valid && m_rdy[k];
    if (flush) begin
      m_live[k] = 1'b0; m_t[k] = 0; m_pf[k] = 1'b0;
    end else if (!m_live[k]) begin
      if (acc) begin m_act[k] = din; m_live[k] = 1'b1; m_t[k] = 0; end
    end else if (m_t[k] == 16 * bc[k] - 1) begin
      m_t[k] = 0;
      if (m_pf[k]) begin
        m_act[k] = m_pend[k];
        if (acc) m_pend[k] = din; else m_pf[k] = 1'b0;
      end else if (acc) m_act[k] = din;
      else m_live[k] = 1'b0;
    end else begin
      m_t[k]++;
      if (acc) begin m_pend[k] = din; m_pf[k] = 1'b1; end
    end
    m_rdy[k] = !m_pf[k];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = '0; m_t[k] = 0; m_live[k] = 0; m_pf[k] = 0; m_rdy[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  function automatic logic [9:0] exp_stat(input int k);
    logic [3:0] s;
    s = m_live[k] ? 4'(m_t[k] / bc[k]) : 4'd0;
    return {m_rdy[k], m_live[k], m_live[k] && (m_t[k] < bc[k]),
            m_live[k] && (m_t[k] == 16 * bc[k] - 1), m_live[k] | m_pf[k],
            m_act[k][15 - s], s};
  endfunction

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stat%0d", k), 32'({rdy[k], sv[k], sf[k], sl[k], bz[k], so[k], sel4[k]}),
          32'(exp_stat(k)));
      chk($sformatf("word%0d", k), 32'(wo[k]), 32'(m_act[k]));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bz[0] || bz[1] || !rdy[0] || !rdy[1]) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", 32'(n < 300), 32'd1);
  endtask

  initial begin
    int ones, lasts, n;
    logic [15:0] pat;
    #1 rst_n = 1'b0;
    in_valid = 1'b1; din = 16'hDEAD;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_valid", 32'(sv[0]), 32'd0);
    chk("rst_sel", 32'(sel4[0]), 32'd0);
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(rdy[0]), 32'd1);
    chk("rel_busy", 32'(bz[0]), 32'd0);

    // Single word on BIT_CYCLES=1: only the last bit is set
    in_valid = 1'b1; din = 16'h0001;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("sw_sel", 32'(sel4[0]), 32'(i - 1));
      chk("sw_out", 32'(so[0]), 32'(i == 16));
      chk("sw_first", 32'(sf[0]), 32'(i == 1));
      chk("sw_last", 32'(sl[0]), 32'(i == 16));
      @(negedge clk);
    end
    chk("sw_idle", 32'(sv[0]), 32'd0);
    wait_idle();

    // Back-to-back: second frame follows with no gap
    in_valid = 1'b1; din = 16'hA5A5;
    @(negedge clk); din = 16'h0F0F;
    @(negedge clk); in_valid = 1'b0;
    chk("b2b_ready", 32'(rdy[0]), 32'd0);
    pat = 16'h0F0F;
    for (int i = 2; i <= 32; i++) begin
      chk("b2b_valid", 32'(sv[0]), 32'd1);
      if (i >= 17) chk("b2b_out", 32'(so[0]), 32'(pat[15 - (i - 17)]));
      @(negedge clk);
    end
    chk("b2b_end", 32'(sv[0]), 32'd0);
    wait_idle();

    // BIT_CYCLES=3 on u3: MSB only, each select held three clocks
    in_valid = 1'b1; din = 16'h8000;
    @(negedge clk); in_valid = 1'b0;
    ones = 0; lasts = 0;
    for (int i = 1; i <= 48; i++) begin
      chk("bc3_out", 32'(so[1]), 32'(i <= 3));
      chk("bc3_last", 32'(sl[1]), 32'(i == 48));
      ones += int'(so[1] && sv[1]);
      lasts += int'(sl[1]);
      @(negedge clk);
    end
    chk("bc3_ones", 32'(ones), 32'd3);
    chk("bc3_lastcnt", 32'(lasts), 32'd1);
    wait_idle();

    // Flush mid-word with pending full and a word offered
    in_valid = 1'b1; din = 16'h1234;
    @(negedge clk); din = 16'h5678;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (sel4[0] != 4'd7 && n < 40) begin @(negedge clk); n++; end
    chk("fl_reach", 32'(n < 40), 32'd1);
    chk("fl_pend", 32'(rdy[0]), 32'd0);
    flush = 1'b1; in_valid = 1'b1; din = 16'hBEEF;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(sv[0]), 32'd0);
    chk("fl_ready", 32'(rdy[0]), 32'd1);
    chk("fl_sel", 32'(sel4[0]), 32'd0);
    chk("fl_word", 32'(wo[0]), 32'h1234);
    for (int i = 0; i < 20; i++) begin
      chk("fl_quiet", 32'(sv[0] | bz[0]), 32'd0);
      @(negedge clk);
    end
    wait_idle();

    // Async reset between edges mid-frame
    in_valid = 1'b1; din = 16'hFFFF;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (sel4[0] != 4'd5 && n < 40) begin @(negedge clk); n++; end
    chk("ar_reach", 32'(n < 40), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(sv[0]), 32'd0);
    chk("ar_sel", 32'(sel4[0]), 32'd0);
    chk("ar_word", 32'(wo[0]), 32'd0);
    chk("ar_busy", 32'(bz[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("ar_quiet", 32'(sv[0]), 32'd0);
      @(negedge clk);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom % 4) != 0;
      din      = 16'($urandom);
      flush    = ($urandom % 50) == 0;
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 16:1 mux (`in[0:15]`, `sel[0:3]`).
- Accepts 16-bit words over a valid/ready handshake and holds each word stable on `word_out`.
- Steps `sel` 0→15 so the downstream mux emits the word serially, index 0 first.
- Has a one-word pending buffer, so back-to-back words stream with no idle cycle; also drives frame markers and a local copy of the selected bit for self-check.

Parameters:
- BIT_CYCLES, 1, clocks each `sel` value is held (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  [0:15]  word to serialise; bit 0 is sent first
- in_valid  input  1  `in_data` valid
- in_ready  output  1  block can accept a word this cycle
- flush  input  1  synchronous abort of active and pending words
- word_out  output  [0:15]  active word, held stable for the mux `in` port
- sel  output  [0:3]  select for the mux `sel` port
- ser_out  output  1  `word_out[sel]` (combinational from registers), for self-check
- ser_valid  output  1  `sel`/`word_out` carry a live bit
- ser_first  output  1  high for the cycles where `sel` = 0 and `ser_valid` = 1
- ser_last  output  1  high for the final cycle of `sel` = 15
- busy  output  1  `ser_valid` OR pending full

Behaviour:
- Reset (asynchronous, `rst_n` = 0) drives:
  - state = IDLE
  - `word_out` = 0, `sel` = 0, hold counter = 0
  - `ser_valid` = 0, `ser_first` = 0, `ser_last` = 0, `busy` = 0
  - pending empty, so `in_ready` = 1 (after release)
- Reset asserted mid-word discards everything; no partial frame resumes.
- Storage: active register plus pending register. `in_ready` = NOT pending_full (registered flag, no combinational path from `in_valid`).
- Accept: `in_valid` AND `in_ready` at a rising edge.
  - In IDLE with nothing pending, the word loads directly into active.
  - Otherwise it loads into pending.
- State IDLE:
  - `ser_valid` = 0.
  - On accept → SHIFT; `word_out` = `in_data`, `sel` = 0, `ser_valid` = 1 from the cycle after the accept edge.
  - Latency: one clock from accept to the first bit.
- State SHIFT:
  - Hold counter counts 0..BIT_CYCLES-1. At terminal count, `sel` increments and the counter returns to 0.
  - `ser_last` = (`sel` == 15) AND (counter == BIT_CYCLES-1).
  - At the `ser_last` edge:
    - pending full: `word_out` ← pending, `sel` ← 0, pending cleared, stay in SHIFT (zero gap).
    - pending empty but accept on the same edge: the new word loads directly into active, `sel` ← 0 (zero gap).
    - otherwise → IDLE; `sel` returns to 0, `word_out` holds its last value.
- Simultaneous accept and pending-drain on the `ser_last` edge: pending takes the new word, active takes the old pending word; `in_ready` stays 0 only if pending ends full.
- Flush:
  - Has priority over everything, including a same-cycle accept (that word is dropped).
  - Next cycle: IDLE, pending empty, `sel` = 0, `ser_valid` = 0, `word_out` unchanged.
- `sel` wraps only through the reload/IDLE paths above; it never counts past 15.
- `word_out` never changes while `ser_valid` = 1 except at a `ser_last` edge.

Test Plan:
- Reset: hold `rst_n` = 0 while asserting `in_valid` → `in_ready` = 0 during reset, then 1 after release; `ser_valid` = 0, `sel` = 0000; no word captured.
- Single word, BIT_CYCLES = 1: `in_data` = 16'b0000000000000001 accepted at cycle 0 → cycles 1..16 give `sel` = 0..15, `ser_out` = 1 only at `sel` = 1111, `ser_first` at cycle 1, `ser_last` at cycle 16, IDLE at cycle 17.
- Back-to-back: 16'hA5A5 then 16'h0F0F offered continuously → `in_ready` drops after the second accept; `sel` 1111 → 0000 with no `ser_valid` gap; second frame `ser_out` sequence = 0,0,0,0,1,1,1,1 ×2.
- BIT_CYCLES = 3: word 16'h8000 → each `sel` held 3 clocks; `ser_out` = 1 for exactly the first 3 valid cycles; `ser_last` is a single pulse at cycle 48.
- Flush mid-word: flush at `sel` = 0111 with pending full and `in_valid` = 1 → next cycle IDLE, `ser_valid` = 0, `in_ready` = 1, offered word not captured.
- Async reset mid-frame: `rst_n` pulsed low between edges at `sel` = 0101 → outputs clear immediately; no resumption after release.
